pll_reset_sequencer: RTL

// Sits directly downstream of the 25->3.125 MHz PLL and consumes its LOCK output.

---
 rtl/pll_reset_sequencer_if.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings: the PLL lock
// input plus the reset, status and debug outputs.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] loss_count;
  logic [7:0] timeout_count;

  modport master (
    input  locked,
    output pll_rst, sys_rst_n, ready, state, loss_count, timeout_count
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst_n, ready, state, loss_count, timeout_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL LOCK into a debounced system reset, kicks the PLL when
// lock never arrives, and counts lock-loss and lock-timeout events.
module pll_reset_sequencer #(
  parameter int MIN_HOLD_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOSS_FILTER_CYCLES = 4,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int CNT_W              = 17
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  pll_reset_sequencer_if.master  seq
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_PLL_RST   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MIN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYCLES - 1);

  logic             sync_q;
  logic             lock_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [7:0]       loss_q, timeout_q;
  logic             loss_inc, timeout_inc;

  // Two-flop synchroniser; every decision below looks at lock_s only.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= seq.locked;
      lock_s <= sync_q;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      filt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    filt_d      = '0;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle wins over the PLL kick.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_PLL_RST;
          cnt_d       = '0;
          timeout_inc = 1'b1;
        end
      end
      S_PLL_RST: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          if (filt_q == FILTER_LAST) begin
            state_d  = S_HOLD;
            loss_inc = 1'b1;
          end else begin
            filt_d = filt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Event counters saturate rather than wrap so a flapping PLL stays visible.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      loss_q    <= '0;
      timeout_q <= '0;
    end else begin
      if (loss_inc && loss_q != 8'hff)       loss_q    <= loss_q + 8'd1;
      if (timeout_inc && timeout_q != 8'hff) timeout_q <= timeout_q + 8'd1;
    end
  end

  assign seq.pll_rst       = (state_q == S_PLL_RST);
  assign seq.sys_rst_n     = (state_q == S_RUN);
  assign seq.ready         = (state_q == S_RUN);
  assign seq.state         = state_q;
  assign seq.loss_count    = loss_q;
  assign seq.timeout_count = timeout_q;

endmodule
